// File: rtl/ef_qspi_xip_line_reader_pkg.sv
// Shared constants, FSM encoding and nibble helper for the QSPI XIP line reader.
package ef_qspi_xip_line_reader_pkg;

    localparam logic [7:0] CMD_SQI_FREAD = 8'hEB;
    localparam logic [7:0] MODE_CONT     = 8'hA0;
    localparam logic [7:0] MODE_NONE     = 8'hFF;

    // Phase lengths in sck cycles (one nibble per sck).
    localparam logic [7:0] CMD_LEN  = 8'd2;
    localparam logic [7:0] ADDR_LEN = 8'd6;
    localparam logic [7:0] MODE_LEN = 8'd2;
    localparam logic [7:0] EXIT_LEN = 8'd2;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StMode,
        StDummy,
        StData,
        StDesel,
        StExit
    } state_e;

    // Nibble driven on dout for sck number idx of phase st.
    function automatic logic [3:0] tx_nibble(state_e st, logic [7:0] idx, logic [23:0] addr,
                                             logic [7:0] mode);
        logic [3:0]  nib;
        logic [23:0] sh;
        nib = 4'h0;
        sh  = addr << {idx, 2'b00};
        case (st)
            StCmd:   nib = idx[0] ? CMD_SQI_FREAD[3:0] : CMD_SQI_FREAD[7:4];
            StAddr:  nib = sh[23:20];
            StMode:  nib = idx[0] ? mode[3:0] : mode[7:4];
            StExit:  nib = 4'hF;
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/ef_qspi_xip_line_reader_if.sv
// Cache-side request/write bus plus flash SQI pins of the line reader.
// slave: the line reader itself; master: cache fill logic + flash pads.
interface ef_qspi_xip_line_reader_if #(
    parameter int unsigned LINE_BYTES = 16
);
    localparam int unsigned IDX_W = $clog2(LINE_BYTES);

    logic             rd_req;
    logic [23:0]      rd_addr;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_data;
    logic             sck;
    logic             ce_n;
    logic [3:0]       din;
    logic [3:0]       dout;
    logic [3:0]       douten;

    modport master (
        output rd_req, rd_addr, din,
        input  busy, done, wr_en, wr_idx, wr_data, sck, ce_n, dout, douten
    );

    modport slave (
        input  rd_req, rd_addr, din,
        output busy, done, wr_en, wr_idx, wr_data, sck, ce_n, dout, douten
    );

endinterface

// File: rtl/ef_qspi_xip_line_reader.sv
// Flash-side line-fill engine: one SQI Fast Read (EBh) per request, bytes streamed to the
// cache line buffer, then a chip-deselect interval.
// Build option: define EF_QSPI_XIP_CONT_READ_EN for continuous-read mode (mode byte A0h,
// CMD skipped after the first transaction, mode-exit sequence after reset).
module ef_qspi_xip_line_reader
    import ef_qspi_xip_line_reader_pkg::*;
#(
    parameter int unsigned LINE_BYTES     = 16,
    parameter int unsigned DUMMY_CYCLES   = 4,
    parameter int unsigned CS_HIGH_CYCLES = 4
) (
    input logic                      HCLK,
    input logic                      HRESETn,
    ef_qspi_xip_line_reader_if.slave bus
);

    localparam int unsigned IDX_W     = $clog2(LINE_BYTES);
    localparam logic [7:0]  DATA_LEN  = 8'(2 * LINE_BYTES);
    localparam logic [7:0]  DUMMY_LEN = 8'(DUMMY_CYCLES);
    localparam logic [7:0]  CS_LAST   = 8'(CS_HIGH_CYCLES - 1);
    localparam logic [23:0] ADDR_MASK = ~(24'(LINE_BYTES) - 24'd1);

`ifdef EF_QSPI_XIP_CONT_READ_EN
    localparam logic CONT_EN = 1'b1;
`else
    localparam logic CONT_EN = 1'b0;
`endif

    localparam logic [7:0] MODE_BYTE = CONT_EN ? MODE_CONT : MODE_NONE;

    state_e           state_q, state_d, start_st;
    logic [7:0]       cnt_q, cnt_d;          // sck index within the current phase
    logic [7:0]       phase_len;
    logic             ph_q, ph_d;            // 0: phase A (sck low), 1: phase B (sck high)
    logic             sck_q, sck_d;
    logic             ce_n_q, ce_n_d;
    logic [3:0]       dout_q, dout_d;
    logic [3:0]       douten_q, douten_d;
    logic [23:0]      addr_q, addr_d;
    logic [3:0]       hi_q, hi_d;
    logic [7:0]       byte_q, byte_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             byte_vld_q, byte_vld_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic [7:0]       cs_cnt_q, cs_cnt_d;
    logic             cont_q, cont_d;        // flash is in continuous-read mode
    logic             exit_q, exit_d;        // mode-exit sequence still owed after reset

    // Length of the current bus phase in sck cycles.
    always_comb begin
        phase_len = 8'd1;
        case (state_q)
            StCmd:   phase_len = CMD_LEN;
            StAddr:  phase_len = ADDR_LEN;
            StMode:  phase_len = MODE_LEN;
            StDummy: phase_len = DUMMY_LEN;
            StData:  phase_len = DATA_LEN;
            StExit:  phase_len = EXIT_LEN;
            default: phase_len = 8'd1;
        endcase
    end

    // Next-state logic: sck phase toggle, nibble sequencing, din capture and deselect timing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        sck_d      = sck_q;
        ce_n_d     = ce_n_q;
        dout_d     = dout_q;
        douten_d   = douten_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        byte_d     = byte_q;
        byte_idx_d = byte_idx_q;
        byte_vld_d = 1'b0;
        done_d     = 1'b0;
        cs_cnt_d   = cs_cnt_q;
        cont_d     = cont_q;
        exit_d     = exit_q;
        start_st   = cont_q ? StAddr : StCmd;

        // Byte writes trail the second-nibble capture by one HCLK.
        wr_en_d   = byte_vld_q;
        wr_idx_d  = byte_vld_q ? byte_idx_q : wr_idx_q;
        wr_data_d = byte_vld_q ? byte_q : wr_data_q;

        unique case (state_q)
            StIdle: begin
                sck_d    = 1'b0;
                ce_n_d   = 1'b1;
                dout_d   = 4'h0;
                douten_d = 4'h0;
                if (exit_q) begin
                    exit_d   = 1'b0;
                    state_d  = StExit;
                    ce_n_d   = 1'b0;
                    cnt_d    = 8'd0;
                    ph_d     = 1'b0;
                    dout_d   = 4'hF;
                    douten_d = 4'hF;
                end else if (bus.rd_req) begin
                    addr_d   = bus.rd_addr & ADDR_MASK;
                    state_d  = start_st;
                    ce_n_d   = 1'b0;
                    cnt_d    = 8'd0;
                    ph_d     = 1'b0;
                    douten_d = 4'hF;
                    dout_d   = tx_nibble(start_st, 8'd0, bus.rd_addr & ADDR_MASK, MODE_BYTE);
                end
            end

            StDesel: begin
                if (cs_cnt_q == CS_LAST) begin
                    state_d = StIdle;
                end else begin
                    cs_cnt_d = cs_cnt_q + 8'd1;
                end
            end

            default: begin
                if (!ph_q) begin
                    if (state_q == StData && cnt_q == DATA_LEN) begin
                        // Tail cycle after the last sck: last byte is being written.
                        state_d  = StDesel;
                        ce_n_d   = 1'b1;
                        done_d   = 1'b1;
                        cs_cnt_d = 8'd0;
                    end else begin
                        ph_d  = 1'b1;
                        sck_d = 1'b1;
                        if (state_q == StData) begin
                            if (!cnt_q[0]) begin
                                hi_d = bus.din;
                            end else begin
                                byte_d     = {hi_q, bus.din};
                                byte_idx_d = cnt_q[IDX_W:1];
                                byte_vld_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    ph_d  = 1'b0;
                    sck_d = 1'b0;
                    if (cnt_q != phase_len - 8'd1) begin
                        cnt_d  = cnt_q + 8'd1;
                        dout_d = tx_nibble(state_q, cnt_q + 8'd1, addr_q, MODE_BYTE);
                    end else begin
                        cnt_d = 8'd0;
                        case (state_q)
                            StCmd:   state_d = StAddr;
                            StAddr:  state_d = StMode;
                            StMode: begin
                                state_d  = StDummy;
                                douten_d = 4'h0;
                                cont_d   = CONT_EN;
                            end
                            StDummy: state_d = StData;
                            StData:  cnt_d = DATA_LEN;
                            StExit: begin
                                state_d  = StDesel;
                                ce_n_d   = 1'b1;
                                douten_d = 4'h0;
                                cs_cnt_d = 8'd0;
                            end
                            default: state_d = StIdle;
                        endcase
                        dout_d = tx_nibble(state_d, cnt_d, addr_q, MODE_BYTE);
                    end
                end
            end
        endcase
    end

    // State and output registers; reset drops the pins immediately and discards a partial line.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            ph_q       <= 1'b0;
            sck_q      <= 1'b0;
            ce_n_q     <= 1'b1;
            dout_q     <= 4'h0;
            douten_q   <= 4'h0;
            addr_q     <= 24'h0;
            hi_q       <= 4'h0;
            byte_q     <= 8'h0;
            byte_idx_q <= '0;
            byte_vld_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= 8'h0;
            done_q     <= 1'b0;
            cs_cnt_q   <= 8'd0;
            cont_q     <= 1'b0;
            exit_q     <= CONT_EN;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            sck_q      <= sck_d;
            ce_n_q     <= ce_n_d;
            dout_q     <= dout_d;
            douten_q   <= douten_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            byte_q     <= byte_d;
            byte_idx_q <= byte_idx_d;
            byte_vld_q <= byte_vld_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            cs_cnt_q   <= cs_cnt_d;
            cont_q     <= cont_d;
            exit_q     <= exit_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_idx  = wr_idx_q;
    assign bus.wr_data = wr_data_q;
    assign bus.sck     = sck_q;
    assign bus.ce_n    = ce_n_q;
    assign bus.dout    = dout_q;
    assign bus.douten  = douten_q;

endmodule

// File: tb/tb_ef_qspi_xip_line_reader.sv
// Self-checking bench for ef_qspi_xip_line_reader (default build, 16-byte lines).
// Flash model: byte[a] = a[7:0]; it decodes the address from the SQI stream.
module tb_ef_qspi_xip_line_reader;

    localparam int unsigned LB = 16;

    logic HCLK;
    logic HRESETn;
    int   n_cmp = 0;
    int   n_bad = 0;

    ef_qspi_xip_line_reader_if #(.LINE_BYTES(LB)) bus ();

    ef_qspi_xip_line_reader #(
        .LINE_BYTES(LB),
        .DUMMY_CYCLES(4),
        .CS_HIGH_CYCLES(4)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- flash model ----------------
    int          rise_cnt = 0;
    int          last_rises = 0;
    int          oe_bad = 0;
    logic [3:0]  mosi [0:15];
    logic [23:0] cap_addr;
    logic [23:0] fa;
    logic [3:0]  din_m;
    int          m;

    // Log each sck rise: outgoing nibble and whether douten suits the phase.
    always @(posedge bus.sck or posedge bus.ce_n) begin
        if (bus.ce_n) begin
            last_rises <= rise_cnt;
            rise_cnt   <= 0;
        end else begin
            if (rise_cnt < 16) mosi[rise_cnt] <= bus.dout;
            if (bus.douten !== ((rise_cnt < 10) ? 4'hF : 4'h0)) oe_bad <= oe_bad + 1;
            rise_cnt <= rise_cnt + 1;
        end
    end

    // Present the nibble for the next rise (data starts at rise 14).
    always_comb begin
        cap_addr = {mosi[2], mosi[3], mosi[4], mosi[5], mosi[6], mosi[7]};
        m        = rise_cnt - 14;
        fa       = cap_addr + 24'(m / 2);
        din_m    = 4'h0;
        if (rise_cnt >= 14) din_m = m[0] ? fa[3:0] : fa[7:4];
    end
    assign bus.din = din_m;

    // ---------------- pin monitors ----------------
    int bad_sck = 0;
    int bad_oe_val = 0;
    int done_total = 0;
    int gap_cnt = 0;
    int last_gap = 0;

    always @(negedge HCLK) begin
        if (bus.ce_n === 1'b1 && bus.sck !== 1'b0) bad_sck++;
        if (bus.douten !== 4'h0 && bus.douten !== 4'hF) bad_oe_val++;
        if (bus.done === 1'b1) done_total++;
        if (bus.ce_n === 1'b1) begin
            gap_cnt++;
        end else if (gap_cnt != 0) begin
            last_gap = gap_cnt;
            gap_cnt  = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] line [0:LB-1];
    int         done_cyc, busy_low_cyc, n_done, n_wr, seq_bad;
    logic       ce1, busy1;

    // Call right after a negedge with busy=0; that cycle is cycle 0.
    task automatic run_fill(input logic [23:0] addr, input bit hold, input logic [23:0] next_addr);
        for (int k = 0; k < LB; k++) line[k] = 8'hEE;
        done_cyc     = -1;
        busy_low_cyc = -1;
        n_done       = 0;
        n_wr         = 0;
        seq_bad      = 0;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = addr;
        @(posedge HCLK);
        for (int n = 1; n <= 300; n++) begin
            @(negedge HCLK);
            if (n == 1) begin
                ce1   = bus.ce_n;
                busy1 = bus.busy;
                if (hold) bus.rd_addr = next_addr;
                else bus.rd_req = 1'b0;
            end
            if (bus.wr_en === 1'b1) begin
                if (32'(bus.wr_idx) != n_wr) seq_bad++;
                line[bus.wr_idx] = bus.wr_data;
                n_wr++;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (bus.busy === 1'b0) begin
                busy_low_cyc = n;
                break;
            end
        end
    endtask

    task automatic check_fill(input string name, input logic [23:0] base, input int exp_done,
                              input int exp_busy_low);
        logic [7:0] eb;
        chk({name, " ce_n@1"}, 32'(ce1), 32'd0);
        chk({name, " busy@1"}, 32'(busy1), 32'd1);
        chk({name, " cmd"}, {24'h0, mosi[0], mosi[1]}, 32'h0000_00EB);
        chk({name, " addr"}, {8'h0, cap_addr}, {8'h0, base});
        chk({name, " mode"}, {24'h0, mosi[8], mosi[9]}, 32'h0000_00FF);
        chk({name, " sck rises"}, 32'(last_rises), 32'd46);
        chk({name, " done cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({name, " done count"}, 32'(n_done), 32'd1);
        chk({name, " busy low cycle"}, 32'(busy_low_cyc), 32'(exp_busy_low));
        chk({name, " writes"}, 32'(n_wr), 32'(LB));
        chk({name, " wr_idx order"}, 32'(seq_bad), 32'd0);
        for (int k = 0; k < LB; k++) begin
            eb = base[7:0] + 8'(k);
            chk($sformatf("%s byte%0d", name, k), {24'h0, line[k]}, {24'h0, eb});
        end
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [23:0] base;
        logic [31:0] word4;
        int          done_cyc;
        int          busy_low;
    } vec_t;

    vec_t vecs [3];
    int   d0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{24'h000000, 24'h000000, 32'h07060504, 94, 98};
        vecs[1] = '{24'h000027, 24'h000020, 32'h27262524, 94, 98};
        vecs[2] = '{24'hFFFFF5, 24'hFFFFF0, 32'hF7F6F5F4, 94, 98};

        HRESETn     = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = 24'h0;
        repeat (3) @(negedge HCLK);

        chk("reset ce_n", 32'(bus.ce_n), 32'd1);
        chk("reset sck", 32'(bus.sck), 32'd0);
        chk("reset douten", 32'(bus.douten), 32'd0);
        chk("reset dout", 32'(bus.dout), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset wr_idx", 32'(bus.wr_idx), 32'd0);
        chk("reset wr_data", 32'(bus.wr_data), 32'd0);

        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // Table-driven single fills.
        for (int v = 0; v < 3; v++) begin
            run_fill(vecs[v].addr, 1'b0, 24'h0);
            check_fill($sformatf("vec%0d", v), vecs[v].base, vecs[v].done_cyc, vecs[v].busy_low);
            chk($sformatf("vec%0d word4", v), {line[7], line[6], line[5], line[4]},
                vecs[v].word4);
        end

        // rd_req held high through a fill; the second address waits for busy=0.
        run_fill(24'h000000, 1'b1, 24'h000030);
        check_fill("b2b first", 24'h000000, 94, 98);
        run_fill(24'h000030, 1'b0, 24'h0);
        check_fill("b2b second", 24'h000030, 94, 98);
        chk("b2b ce_n gap >= 4", 32'(last_gap >= 4), 32'd1);

        // Asynchronous reset in the middle of the data phase.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 24'h000040;
        @(posedge HCLK);
        for (int n = 1; n <= 40; n++) begin
            @(negedge HCLK);
            if (n == 1) bus.rd_req = 1'b0;
        end
        d0 = done_total;
        HRESETn = 1'b0;
        #1;
        chk("midreset ce_n", 32'(bus.ce_n), 32'd1);
        chk("midreset sck", 32'(bus.sck), 32'd0);
        chk("midreset douten", 32'(bus.douten), 32'd0);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset wr_en", 32'(bus.wr_en), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (8) @(negedge HCLK);
        #1;
        chk("midreset no done", 32'(done_total), 32'(d0));
        chk("midreset idle", 32'(bus.busy), 32'd0);
        run_fill(24'h000010, 1'b0, 24'h0);
        check_fill("after reset", 24'h000010, 94, 98);

        chk("sck quiet while deselected", 32'(bad_sck), 32'd0);
        chk("douten legal values", 32'(bad_oe_val), 32'd0);
        chk("douten per phase", 32'(oe_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ef_qspi_xip_line_reader.md
Name: ef_qspi_xip_line_reader

Overview:
Flash-side line-fill engine of the QSPI XIP controller. It sits between the cache fill logic and the external Quad I/O pins (sck/ce_n/din/dout/douten).
- On a fill request it issues one SQI Fast Read (EBh, all phases 4-bit).
- It streams LINE_BYTES bytes back to the cache as byte writes, then pulses done.
- It targets SST26WF080B-class flash in SQI mode.

Parameters:
LINE_BYTES, 16, bytes per cache line; power of two, 4..64
DUMMY_CYCLES, 4, dummy sck cycles after the mode byte
CS_HIGH_CYCLES, 4, minimum HCLK cycles ce_n stays high between transactions (>=1)

Ports:
HCLK  in  1  clock; all logic on posedge
HRESETn  in  1  asynchronous active-low reset
rd_req  in  1  fill request, sampled only when busy=0
rd_addr  in  24  flash byte address; low log2(LINE_BYTES) bits ignored (forced 0)
busy  out  1  transaction or deselect interval in progress
done  out  1  one-cycle pulse after the last byte is written
wr_en  out  1  byte-write strobe to cache line buffer
wr_idx  out  log2(LINE_BYTES)  byte index within the line
wr_data  out  8  byte value
sck  out  1  flash serial clock
ce_n  out  1  flash chip enable, active low
din  in  4  SIO input
dout  out  4  SIO output
douten  out  4  SIO output enable; always 4'b0000 or 4'b1111

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - ce_n=1, sck=0, douten=0, dout=0.
  - busy=0, done=0, wr_en=0, wr_idx=0, wr_data=0.
  - State returns to IDLE; the partial line is discarded and no done is issued.
- Sck timing:
  - One sck period = 2 HCLK. Phase A: sck=0, dout updated. Phase B: sck=1.
  - din is sampled on the HCLK edge that drives sck 0->1.
  - sck=0 whenever ce_n=1.
- FSM states: IDLE, CMD, ADDR, MODE, DUMMY, DATA, DESEL.
- IDLE:
  - rd_req=1 latches the aligned address; next cycle ce_n=0, busy=1, enter CMD.
  - rd_req while busy=1 is ignored.
- CMD: 2 sck, nibbles E then B, douten=1111.
- ADDR: 6 sck, address MSB nibble first, douten=1111.
- MODE: 2 sck, mode byte 8'hFF, douten=1111.
- DUMMY: DUMMY_CYCLES sck, douten=0000. douten drops on the phase A of the first dummy cycle.
- DATA:
  - 2*LINE_BYTES sck, douten=0000. First nibble of each byte is bits [7:4].
  - wr_en pulses 1 HCLK after the second nibble of each byte is sampled.
  - wr_idx runs 0..LINE_BYTES-1 with no wrap inside a line; byte k = flash[addr+k].
- DESEL:
  - ce_n=1 and sck=0 on the cycle after the last sample.
  - done pulses on that same cycle.
  - busy stays 1 for CS_HIGH_CYCLES, then IDLE.
- Latency, default parameters:
  - rd_req accepted at cycle 0; ce_n falls at cycle 1.
  - 46 sck = 92 HCLK of bus activity.
  - done at cycle 94; busy low at cycle 98.
  - Back-to-back rd_req is accepted the cycle busy=0.
- Addresses near 0xFFFFFF: the flash wraps internally; no special handling in the block.

Optional Feature:
Macro EF_QSPI_XIP_CONT_READ_EN.
- Defined:
  - Mode byte is 8'hA0 (continuous read); every transaction after the first skips CMD and starts at ADDR (46 -> 44 sck).
  - After HRESETn deasserts, a mode-exit sequence runs first: ce_n low, 2 sck with dout=4'hF and douten=1111, then DESEL. busy=1 throughout.
  - The next request then sends CMD.
- Undefined: mode byte 8'hFF; every transaction includes CMD; no post-reset sequence.

Decomposition:
- Shared include ef_qspi_xip_pkg.vh holds:
  - localparams CMD_SQI_FREAD=8'hEB, MODE_CONT=8'hA0, MODE_NONE=8'hFF;
  - FSM state encodings;
  - phase-length constants (CMD 2, ADDR 6, MODE 2).
- Single module; a sub-module is not natural. Sck phase toggle, nibble shifter and phase counter stay inline.

Test Plan:
- Flash preloaded with byte[i]=i[7:0]. rd_req with rd_addr=0x000000 -> command nibbles E,B; address nibbles 0x000000; wr_en x16 with (wr_idx,wr_data)=(0,00)..(15,0F); done at cycle 94; busy low at 98.
- rd_req with rd_addr=0x000027 -> aligned to 0x000020; bytes 20..2F; cache word at index 4 reads 0x27262524.
- rd_req held high during busy, second address 0x000030 -> ignored until busy=0; second transaction then fetches 30..3F; ce_n high >=4 HCLK between transactions.
- HRESETn low at cycle 40 of a fill -> ce_n=1, sck=0, douten=0 same cycle; no done; next fill at 0x000010 returns 10..1F correctly.
- douten/sck checks over a full fill -> douten=1111 only in CMD/ADDR/MODE; sck never toggles while ce_n=1; exactly 46 sck rising edges.
- With EF_QSPI_XIP_CONT_READ_EN: post-reset exit sequence observed (2 sck of F); first fill sends EB and mode A0; second fill has no CMD, 44 sck, data correct.
